// File: rtl/imem_program_encoder_if.sv
// Field-set stream into the RV32I program encoder: valid/ready handshake plus
// the instruction fields sampled on accept.
interface imem_program_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_cls;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [12:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_cls, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_cls, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/imem_program_encoder.sv
// Encodes R / I-ALU / LOAD / STORE / BEQ field sets into RV32I words and writes
// them to instruction memory at consecutive word addresses.
module imem_program_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  imem_program_encoder_if.slave in_if,
  output logic                  imem_we,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_W:0]       word_count,
  output logic                  done,
  output logic                  full,
  output logic                  err_illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic {
    ST_LOADING,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        legal;
  logic        imm_fits12;
  logic [31:0] word_d;

  // word_count never exceeds 2**ADDR_W, so its MSB is exactly the full flag and
  // its low bits are the next write address.
  assign full        = word_count[ADDR_W];
  assign done        = (state_q == ST_DONE);
  assign in_if.in_ready = (state_q == ST_LOADING) & ~full & ~clear & ~reset;
  assign accept      = in_if.in_valid & in_if.in_ready;
  assign imm_fits12  = (in_if.in_imm[12] == in_if.in_imm[11]);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    legal  = 1'b0;
    word_d = '0;
    case (in_if.in_cls)
      3'd0: begin
        legal  = 1'b1;
        word_d = {in_if.in_funct7, in_if.in_rs2, in_if.in_rs1, in_if.in_funct3, in_if.in_rd, OP_R};
      end
      3'd1: begin
        legal  = imm_fits12;
        word_d = {in_if.in_imm[11:0], in_if.in_rs1, in_if.in_funct3, in_if.in_rd, OP_I};
      end
      3'd2: begin
        legal  = imm_fits12;
        word_d = {in_if.in_imm[11:0], in_if.in_rs1, in_if.in_funct3, in_if.in_rd, OP_LOAD};
      end
      3'd3: begin
        legal  = imm_fits12;
        word_d = {in_if.in_imm[11:5], in_if.in_rs2, in_if.in_rs1, in_if.in_funct3,
                  in_if.in_imm[4:0], OP_STORE};
      end
      3'd4: begin
        // Branch offsets are halfword-aligned; funct3 is forced to BEQ.
        legal  = ~in_if.in_imm[0];
        word_d = {in_if.in_imm[12], in_if.in_imm[10:5], in_if.in_rs2, in_if.in_rs1, 3'b000,
                  in_if.in_imm[4:1], in_if.in_imm[11], OP_BEQ};
      end
      default: begin
        legal  = 1'b0;
        word_d = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_LOADING;
    end else if (accept && in_if.in_last) begin
      state_d = ST_DONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOADING;
      word_count  <= '0;
      err_illegal <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
    end else begin
      state_q <= state_d;
      imem_we <= accept & legal;
      // A write registered on the previous edge is already on the imem port,
      // so clear only affects bookkeeping, never that write.
      if (clear) begin
        word_count  <= '0;
        err_illegal <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          imem_addr  <= word_count[ADDR_W-1:0];
          imem_wdata <= word_d;
          word_count <= word_count + (ADDR_W+1)'(1);
        end else begin
          err_illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_program_encoder.sv
// Bench for imem_program_encoder (ADDR_W=2): directed vector table, then
// randomized traffic checked against an arithmetic reference model.
module tb_imem_program_encoder;

  localparam int ADDR_W = 2;
  localparam int CAP    = 4;

  logic              clk;
  logic              reset;
  logic              clear;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              done;
  logic              full;
  logic              err_illegal;

  imem_program_encoder_if bus ();

  imem_program_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_if      (bus.slave),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_count (word_count),
    .done       (done),
    .full       (full),
    .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic clr, input logic vld, input logic [2:0] cls,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [12:0] imm,
                       input logic last);
    reset         = rst;
    clear         = clr;
    bus.in_valid  = vld;
    bus.in_cls    = cls;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    bus.in_last   = last;
  endtask

  // Inputs for one cycle; rdy is sampled before the edge, the rest after it.
  typedef struct {
    logic        rst, clr, vld;
    logic [2:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [12:0] imm;
    logic        last;
    logic        rdy, we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  cnt;
    logic        done, full, err;
  } vec_t;

  vec_t vq[$];

  // Reference encoder: assembles the word from the format rules with integer
  // shifts and decides legality from the signed immediate value.
  task automatic ref_encode(input int cls, input int rd, input int rs1, input int rs2,
                            input int f3, input int f7, input int immv,
                            output bit ok, output logic [31:0] w);
    longint acc;
    int     u;
    ok  = 1'b1;
    acc = 0;
    u   = immv & 'hFFF;
    case (cls)
      0: acc = (longint'(f7) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33;
      1, 2: begin
        ok  = (immv >= -2048) && (immv <= 2047);
        acc = (longint'(u) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + ((cls == 1) ? 'h13 : 'h03);
      end
      3: begin
        ok  = (immv >= -2048) && (immv <= 2047);
        acc = (longint'(u / 32) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + ((u % 32) << 7) + 'h23;
      end
      4: begin
        ok  = (immv % 2) == 0;
        u   = immv & 'h1FFF;
        acc = (longint'(u / 4096) << 31) + (longint'((u / 32) % 64) << 25) + (rs2 << 20)
              + (rs1 << 15) + (((u / 2) % 16) << 8) + (((u / 2048) % 2) << 7) + 'h63;
      end
      default: ok = 1'b0;
    endcase
    w = acc[31:0];
  endtask

  initial begin
    int          m_count;
    bit          m_done, m_err, m_we, ok, m_rdy;
    int          m_waddr;
    logic [31:0] m_wdata, w;

    // Column order: rst clr vld cls rd rs1 rs2 f3 f7 imm last | rdy we addr wdata cnt done full err
    vq.push_back('{1,0,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 0,0,2'd0,32'h00000000,3'd0,0,0,0});
    vq.push_back('{0,0,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 1,1,2'd0,32'h002081B3,3'd1,0,0,0});
    vq.push_back('{0,0,1,3'd2,5'd5,5'd2,5'd0,3'd2,7'h00,13'h0008,0, 1,1,2'd1,32'h00812283,3'd2,0,0,0});
    vq.push_back('{0,0,1,3'd3,5'd0,5'd2,5'd5,3'd2,7'h00,13'h000C,0, 1,1,2'd2,32'h00512623,3'd3,0,0,0});
    vq.push_back('{0,0,0,3'd0,5'd0,5'd0,5'd0,3'd0,7'h00,13'h0000,0, 1,0,2'd0,32'h00000000,3'd3,0,0,0});
    vq.push_back('{0,1,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 0,0,2'd0,32'h00000000,3'd0,0,0,0});
    vq.push_back('{0,0,1,3'd4,5'd0,5'd1,5'd2,3'd7,7'h00,13'h1FF8,0, 1,1,2'd0,32'hFE208CE3,3'd1,0,0,0});
    vq.push_back('{0,0,1,3'd5,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 1,0,2'd0,32'h00000000,3'd1,0,0,1});
    vq.push_back('{0,0,1,3'd4,5'd0,5'd1,5'd2,3'd0,7'h00,13'h0003,0, 1,0,2'd0,32'h00000000,3'd1,0,0,1});
    vq.push_back('{0,0,1,3'd1,5'd1,5'd0,5'd0,3'd0,7'h00,13'h0800,0, 1,0,2'd0,32'h00000000,3'd1,0,0,1});
    vq.push_back('{0,0,1,3'd1,5'd1,5'd0,5'd0,3'd0,7'h00,13'h1FFF,0, 1,1,2'd1,32'hFFF00093,3'd2,0,0,1});
    vq.push_back('{0,0,1,3'd0,5'd4,5'd3,5'd1,3'd0,7'h20,13'h0000,0, 1,1,2'd2,32'h40118233,3'd3,0,0,1});
    vq.push_back('{0,0,1,3'd1,5'd2,5'd2,5'd0,3'd0,7'h00,13'h0001,0, 1,1,2'd3,32'h00110113,3'd4,0,1,1});
    vq.push_back('{0,0,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 0,0,2'd0,32'h00000000,3'd4,0,1,1});
    vq.push_back('{0,0,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 0,0,2'd0,32'h00000000,3'd4,0,1,1});
    vq.push_back('{0,1,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 0,0,2'd0,32'h00000000,3'd0,0,0,0});
    vq.push_back('{0,0,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 1,1,2'd0,32'h002081B3,3'd1,0,0,0});
    vq.push_back('{0,0,1,3'd2,5'd5,5'd2,5'd0,3'd2,7'h00,13'h0008,1, 1,1,2'd1,32'h00812283,3'd2,1,0,0});
    vq.push_back('{0,0,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 0,0,2'd0,32'h00000000,3'd2,1,0,0});
    vq.push_back('{0,1,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 0,0,2'd0,32'h00000000,3'd0,0,0,0});
    vq.push_back('{0,0,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 1,1,2'd0,32'h002081B3,3'd1,0,0,0});
    vq.push_back('{1,0,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 0,0,2'd0,32'h00000000,3'd0,0,0,0});
    vq.push_back('{0,0,1,3'd6,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,1, 1,0,2'd0,32'h00000000,3'd0,1,0,1});
    vq.push_back('{0,1,0,3'd0,5'd0,5'd0,5'd0,3'd0,7'h00,13'h0000,0, 0,0,2'd0,32'h00000000,3'd0,0,0,0});
    vq.push_back('{0,0,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 1,1,2'd0,32'h002081B3,3'd1,0,0,0});
    vq.push_back('{0,1,1,3'd0,5'd3,5'd1,5'd2,3'd0,7'h00,13'h0000,0, 0,0,2'd0,32'h00000000,3'd0,0,0,0});

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].clr, vq[i].vld, vq[i].cls, vq[i].rd, vq[i].rs1, vq[i].rs2,
            vq[i].f3, vq[i].f7, vq[i].imm, vq[i].last);
      #1;
      check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vq[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d imem_we", i), 32'(imem_we), 32'(vq[i].we));
      check($sformatf("v%0d word_count", i), 32'(word_count), 32'(vq[i].cnt));
      check($sformatf("v%0d done", i), 32'(done), 32'(vq[i].done));
      check($sformatf("v%0d full", i), 32'(full), 32'(vq[i].full));
      check($sformatf("v%0d err_illegal", i), 32'(err_illegal), 32'(vq[i].err));
      if (vq[i].we || vq[i].rst) begin
        check($sformatf("v%0d imem_addr", i), 32'(imem_addr), 32'(vq[i].addr));
        check($sformatf("v%0d imem_wdata", i), imem_wdata, vq[i].wdata);
      end
    end

    // Random traffic; the table ended with a clear, so the model starts empty.
    m_count = 0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_we    = 1'b0;
    m_waddr = 0;
    m_wdata = '0;
    for (int c = 0; c < 3000; c++) begin
      logic [2:0]  r_cls;
      logic [12:0] r_imm;
      r_cls = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      r_imm = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 15) - 8) : 13'($urandom);
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
            r_cls, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
            r_imm, $urandom_range(0, 29) == 0);
      #1;
      m_rdy = !reset && !clear && !m_done && (m_count < CAP);
      check($sformatf("r%0d in_ready", c), 32'(bus.in_ready), 32'(m_rdy));

      ref_encode(int'(bus.in_cls), int'(bus.in_rd), int'(bus.in_rs1), int'(bus.in_rs2),
                 (bus.in_cls == 3'd4) ? 0 : int'(bus.in_funct3), int'(bus.in_funct7),
                 int'($signed(bus.in_imm)), ok, w);
      m_we = 1'b0;
      if (reset) begin
        m_count = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_waddr = 0;
        m_wdata = '0;
      end else if (clear) begin
        m_count = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
      end else if (m_rdy && bus.in_valid) begin
        if (ok) begin
          m_we    = 1'b1;
          m_waddr = m_count;
          m_wdata = w;
          m_count++;
        end else begin
          m_err = 1'b1;
        end
        if (bus.in_last) m_done = 1'b1;
      end

      @(posedge clk);
      #1;
      check($sformatf("r%0d imem_we", c), 32'(imem_we), 32'(m_we));
      check($sformatf("r%0d word_count", c), 32'(word_count), 32'(m_count));
      check($sformatf("r%0d done", c), 32'(done), 32'(m_done));
      check($sformatf("r%0d full", c), 32'(full), 32'(m_count == CAP));
      check($sformatf("r%0d err_illegal", c), 32'(err_illegal), 32'(m_err));
      if (m_we) begin
        check($sformatf("r%0d imem_addr", c), 32'(imem_addr), 32'(m_waddr));
        check($sformatf("r%0d imem_wdata", c), imem_wdata, m_wdata);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
